subtractor_arbiter: RTL

Round-robin arbiter and sequencer that shares one WIDTH-bit subtractor among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle and computes `a - b` with borrow into a single output register. The result is returned through a valid/ready port tagged with the requester index. It sits between the tile's operand sources and any consumer of differences, so the subtractor is never duplicated per source.

---
 rtl/subtractor_arbiter_if.sv | 29 ++
 rtl/subtractor_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/subtractor_arbiter_if.sv
// Requester/consumer bundle for the shared subtractor: operand handshake in, tagged result out.
interface subtractor_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_diff;
  logic                  res_borrow;
  logic [IDW-1:0]        res_id;

  // Side that presents operands and consumes results
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_diff, res_borrow, res_id
  );

  // Side that arbitrates and produces results
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_diff, res_borrow, res_id
  );
endinterface

// File: rtl/subtractor_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit subtractor among NREQ requesters,
// with a single registered, id-tagged result behind a valid/ready port.
module subtractor_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                 clk,
  input logic                 rst,
  subtractor_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  logic             grant_any;
  logic             ld;
  logic             fire;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [IDW-1:0]   id_q;

  // The result register can take a new value when it is empty or being drained this cycle
  assign ld   = (state == EMPTY) || bus.res_ready;
  assign fire = !rst && ld && grant_any;

  // Search from the requester after the last winner, wrapping round, for the first valid one
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // One-hot ready to the winner only when the result register can load and reset is released
  always_comb begin
    bus.req_ready = '0;
    if (fire) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  // Steer the winner's operands into the shared subtractor
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // The extra top bit of a zero-extended subtraction is exactly the unsigned borrow
  assign sub_full = {1'b0, a_sel} - {1'b0, b_sel};

  // Output FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output FSM next state: a load always leaves us FULL, otherwise an accepted result empties us
  always_comb begin
    state_nxt = state;
    if (fire) begin
      state_nxt = FULL;
    end else if (state == FULL && bus.res_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Output FSM outputs
  always_comb begin
    bus.res_valid = (state == FULL);
  end

  // Result payload and round-robin pointer; both change only on an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      id_q     <= '0;
      last     <= IDW'(NREQ - 1);
    end else if (fire) begin
      diff_q   <= sub_full[WIDTH-1:0];
      borrow_q <= sub_full[WIDTH];
      id_q     <= grant_id;
      last     <= grant_id;
    end
  end

  assign bus.res_diff   = diff_q;
  assign bus.res_borrow = borrow_q;
  assign bus.res_id     = id_q;

endmodule
